// File: rtl/buzzer_driver.sv
// Piezo buzzer driver: synchronises and debounces the combined alarm request,
// then sounds a pulsed tone that the operator can mute for a fixed period.
module buzzer_driver #(
  parameter int unsigned DEBOUNCE  = 4,
  parameter int unsigned TONE_HALF = 2,
  parameter int unsigned BEEP_ON   = 8,
  parameter int unsigned BEEP_OFF  = 8,
  parameter int unsigned MUTE_TIME = 32,
  parameter int unsigned CNT_W     = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic alarm_req,
  input  logic ack,
  output logic buzz,
  output logic beep_on,
  output logic alarm_active,
  output logic muted
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALARM = 2'd1,
    MUTED = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LP_DB_LAST   = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] LP_TONE_LAST = CNT_W'(TONE_HALF - 1);
  localparam logic [CNT_W-1:0] LP_ON_LAST   = CNT_W'(BEEP_ON - 1);
  localparam logic [CNT_W-1:0] LP_OFF_LAST  = CNT_W'(BEEP_OFF - 1);
  localparam logic [CNT_W-1:0] LP_MUTE_LOAD = CNT_W'(MUTE_TIME);
  localparam logic [CNT_W-1:0] LP_ONE       = CNT_W'(1);

  logic             r_sync1;
  logic             r_req_s;
  logic             r_req_db;
  logic [CNT_W-1:0] r_db_cnt;

  state_t           r_state;
  logic             r_phase_on;
  logic [CNT_W-1:0] r_phase_cnt;
  logic [CNT_W-1:0] r_tone_cnt;
  logic             r_tone_lvl;
  logic [CNT_W-1:0] r_mute_cnt;

  logic             r_buzz;
  logic             r_beep_on;
  logic             r_alarm_active;
  logic             r_muted;

  state_t           w_nxt_state;
  logic             w_nxt_phase_on;
  logic [CNT_W-1:0] w_nxt_phase_cnt;
  logic [CNT_W-1:0] w_nxt_tone_cnt;
  logic             w_nxt_tone_lvl;
  logic [CNT_W-1:0] w_nxt_mute_cnt;
  logic [CNT_W-1:0] w_mute_dec;

  logic             w_nxt_buzz;
  logic             w_nxt_beep_on;
  logic             w_nxt_alarm_active;
  logic             w_nxt_muted;

  // The debounced level only flips after DEBOUNCE consecutive disagreeing cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= 1'b0;
      r_req_s  <= 1'b0;
      r_req_db <= 1'b0;
      r_db_cnt <= '0;
    end else begin
      r_sync1 <= alarm_req;
      r_req_s <= r_sync1;
      if (r_req_s == r_req_db) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == LP_DB_LAST) begin
        r_req_db <= ~r_req_db;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + LP_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_phase_on     <= 1'b0;
      r_phase_cnt    <= '0;
      r_tone_cnt     <= '0;
      r_tone_lvl     <= 1'b0;
      r_mute_cnt     <= '0;
      r_buzz         <= 1'b0;
      r_beep_on      <= 1'b0;
      r_alarm_active <= 1'b0;
      r_muted        <= 1'b0;
    end else begin
      r_state        <= w_nxt_state;
      r_phase_on     <= w_nxt_phase_on;
      r_phase_cnt    <= w_nxt_phase_cnt;
      r_tone_cnt     <= w_nxt_tone_cnt;
      r_tone_lvl     <= w_nxt_tone_lvl;
      r_mute_cnt     <= w_nxt_mute_cnt;
      r_buzz         <= w_nxt_buzz;
      r_beep_on      <= w_nxt_beep_on;
      r_alarm_active <= w_nxt_alarm_active;
      r_muted        <= w_nxt_muted;
    end
  end

  // Mute ends on the cycle the decremented count hits zero, so it lasts MUTE_TIME cycles.
  assign w_mute_dec = r_mute_cnt - LP_ONE;

  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_phase_on  = r_phase_on;
    w_nxt_phase_cnt = r_phase_cnt;
    w_nxt_tone_cnt  = r_tone_cnt;
    w_nxt_tone_lvl  = r_tone_lvl;
    w_nxt_mute_cnt  = r_mute_cnt;
    case (r_state)
      IDLE: begin
        if (r_req_db) begin
          w_nxt_state     = ALARM;
          w_nxt_phase_on  = 1'b1;
          w_nxt_phase_cnt = '0;
          w_nxt_tone_cnt  = '0;
          w_nxt_tone_lvl  = 1'b1;
        end
      end
      ALARM: begin
        if (!r_req_db) begin
          w_nxt_state     = IDLE;
          w_nxt_phase_on  = 1'b0;
          w_nxt_phase_cnt = '0;
          w_nxt_tone_cnt  = '0;
          w_nxt_tone_lvl  = 1'b0;
        end else if (ack) begin
          w_nxt_state     = MUTED;
          w_nxt_mute_cnt  = LP_MUTE_LOAD;
          w_nxt_phase_on  = 1'b0;
          w_nxt_phase_cnt = '0;
          w_nxt_tone_cnt  = '0;
          w_nxt_tone_lvl  = 1'b0;
        end else if (r_phase_cnt == (r_phase_on ? LP_ON_LAST : LP_OFF_LAST)) begin
          w_nxt_phase_on  = ~r_phase_on;
          w_nxt_phase_cnt = '0;
          w_nxt_tone_cnt  = '0;
          w_nxt_tone_lvl  = 1'b1;
        end else begin
          w_nxt_phase_cnt = r_phase_cnt + LP_ONE;
          if (r_tone_cnt == LP_TONE_LAST) begin
            w_nxt_tone_cnt = '0;
            w_nxt_tone_lvl = ~r_tone_lvl;
          end else begin
            w_nxt_tone_cnt = r_tone_cnt + LP_ONE;
          end
        end
      end
      MUTED: begin
        if (!r_req_db) begin
          w_nxt_state    = IDLE;
          w_nxt_mute_cnt = '0;
        end else if (w_mute_dec == '0) begin
          w_nxt_state     = ALARM;
          w_nxt_mute_cnt  = '0;
          w_nxt_phase_on  = 1'b1;
          w_nxt_phase_cnt = '0;
          w_nxt_tone_cnt  = '0;
          w_nxt_tone_lvl  = 1'b1;
        end else begin
          w_nxt_mute_cnt = w_mute_dec;
        end
      end
      default: begin
        w_nxt_state = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered pins line up with r_state.
  always_comb begin
    w_nxt_buzz         = 1'b0;
    w_nxt_beep_on      = 1'b0;
    w_nxt_alarm_active = (w_nxt_state != IDLE);
    w_nxt_muted        = (w_nxt_state == MUTED);
    if (w_nxt_state == ALARM) begin
      w_nxt_beep_on = w_nxt_phase_on;
      w_nxt_buzz    = w_nxt_phase_on & w_nxt_tone_lvl;
    end
  end

  assign buzz         = r_buzz;
  assign beep_on      = r_beep_on;
  assign alarm_active = r_alarm_active;
  assign muted        = r_muted;

endmodule

// File: tb/tb_buzzer_driver.sv
// Scoreboard bench for buzzer_driver: stimulus queues expected {buzz,beep_on,alarm_active,muted}
// per clock edge and an independent monitor compares them.
module tb_buzzer_driver;

  logic clk = 1'b0;
  logic rst_n;
  logic alarm_req;
  logic ack;
  logic buzz;
  logic beep_on;
  logic alarm_active;
  logic muted;

  typedef struct {
    int         edgeNo;
    logic [3:0] val;
    string      tag;
  } exp_t;

  exp_t sb[$];
  exp_t monX;
  int   edgeCnt  = 0;
  int   total    = 0;
  int   bad      = 0;
  int   asyncNow = 0;
  event asyncChk;

  logic [15:0] buzzPat = 16'b1100_1100_0000_0000;
  logic [15:0] beepPat = 16'b1111_1111_0000_0000;

  buzzer_driver #(
    .DEBOUNCE(4), .TONE_HALF(2), .BEEP_ON(8), .BEEP_OFF(8), .MUTE_TIME(32), .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .alarm_req(alarm_req),
    .ack(ack),
    .buzz(buzz),
    .beep_on(beep_on),
    .alarm_active(alarm_active),
    .muted(muted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  task automatic applyStimulus(input logic reqVal, input logic ackVal);
    alarm_req = reqVal;
    ack       = ackVal;
  endtask

  task automatic expectAt(input int e, input logic [3:0] v, input string tag);
    exp_t x;
    x.edgeNo = e;
    x.val    = v;
    x.tag    = tag;
    sb.push_back(x);
  endtask

  function automatic logic [3:0] patExp(input int k);
    int idx;
    idx = k % 16;
    return {buzzPat[15-idx], beepPat[15-idx], 1'b1, 1'b0};
  endfunction

  task automatic checkOutput(input exp_t x, input int atEdge);
    logic [3:0] act;
    act = {buzz, beep_on, alarm_active, muted};
    total++;
    if (x.edgeNo != atEdge || act !== x.val) begin
      bad++;
      $display("[TB] FAIL %s edge=%0d due=%0d got=%b want=%b", x.tag, atEdge, x.edgeNo, act, x.val);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic gotoEdge(input int e);
    while (edgeCnt < e) nextCycle();
  endtask

  task automatic waitDrain();
    int guard;
    guard = 0;
    while (sb.size() > 0 && guard < 500) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain pending=%0d want=0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: pops every expectation due at this edge, or the mid-cycle reset check.
  always begin
    @(negedge clk or asyncChk);
    if (asyncNow != 0) begin
      while (sb.size() > 0 && sb[0].edgeNo == -2) begin
        monX = sb.pop_front();
        checkOutput(monX, -2);
      end
    end else begin
      while (sb.size() > 0 && sb[0].edgeNo <= edgeCnt) begin
        monX = sb.pop_front();
        checkOutput(monX, edgeCnt);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int c, f, g, h, p, r;
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0);

    nextCycle();
    expectAt(edgeCnt, 4'b0000, "reset");
    repeat (2) nextCycle();
    rst_n = 1'b1;

    for (int e = edgeCnt; e <= 15; e++) expectAt(e, 4'b0000, "preAlarm");
    for (int k = 0; k < 32; k++) expectAt(16 + k, patExp(k), "pattern");
    gotoEdge(9);
    applyStimulus(1'b1, 1'b0);
    waitDrain();

    nextCycle();
    c = edgeCnt;
    for (int e = c + 1; e <= c + 32; e++) expectAt(e, 4'b0011, "muted");
    expectAt(c + 33, 4'b1110, "rearm0");
    expectAt(c + 34, 4'b1110, "rearm1");
    expectAt(c + 35, 4'b0110, "rearm2");
    expectAt(c + 36, 4'b0110, "rearm3");
    applyStimulus(1'b1, 1'b1);
    gotoEdge(c + 1);
    applyStimulus(1'b1, 1'b0);
    gotoEdge(c + 10);
    applyStimulus(1'b1, 1'b1);
    gotoEdge(c + 11);
    applyStimulus(1'b1, 1'b0);
    waitDrain();

    nextCycle();
    f = edgeCnt;
    for (int e = f + 1; e <= f + 7; e++) expectAt(e, 4'b0011, "muteHold");
    for (int e = f + 8; e <= f + 40; e++) expectAt(e, 4'b0000, "muteClear");
    applyStimulus(1'b1, 1'b1);
    gotoEdge(f + 1);
    applyStimulus(1'b0, 1'b0);
    waitDrain();

    nextCycle();
    g = edgeCnt;
    for (int e = g; e <= g + 15; e++) expectAt(e, 4'b0000, "glitch3");
    applyStimulus(1'b1, 1'b1);
    gotoEdge(g + 3);
    applyStimulus(1'b0, 1'b1);
    gotoEdge(g + 5);
    applyStimulus(1'b0, 1'b0);
    waitDrain();

    nextCycle();
    h = edgeCnt;
    for (int e = h; e <= h + 6; e++) expectAt(e, 4'b0000, "pulse6Pre");
    for (int k = 0; k < 6; k++) expectAt(h + 7 + k, patExp(k), "pulse6Alarm");
    for (int e = h + 13; e <= h + 20; e++) expectAt(e, 4'b0000, "pulse6Idle");
    applyStimulus(1'b1, 1'b0);
    gotoEdge(h + 6);
    applyStimulus(1'b0, 1'b0);
    waitDrain();

    nextCycle();
    p = edgeCnt;
    expectAt(p + 7, 4'b1110, "prioAlarm");
    expectAt(p + 18, 4'b0010, "prioOff");
    for (int e = p + 19; e <= p + 22; e++) expectAt(e, 4'b0000, "prioIdle");
    applyStimulus(1'b1, 1'b0);
    gotoEdge(p + 12);
    applyStimulus(1'b0, 1'b0);
    gotoEdge(p + 18);
    applyStimulus(1'b0, 1'b1);
    gotoEdge(p + 19);
    applyStimulus(1'b0, 1'b0);
    waitDrain();

    nextCycle();
    r = edgeCnt;
    expectAt(r + 7, 4'b1110, "asyncPre");
    applyStimulus(1'b1, 1'b0);
    gotoEdge(r + 8);
    #1;
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0);
    #1;
    expectAt(-2, 4'b0000, "asyncReset");
    asyncNow = 1;
    ->asyncChk;
    #1;
    asyncNow = 0;
    expectAt(r + 9, 4'b0000, "inReset");
    gotoEdge(r + 10);
    rst_n = 1'b1;
    for (int e = r + 11; e <= r + 14; e++) expectAt(e, 4'b0000, "postReset");
    waitDrain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
